// File: rtl/cla_pkg.sv
// Shared definitions for the carry-lookahead sum pipeline and future group/block lookahead units.
package cla_pkg;

   localparam int CLA_WIDTH_DEF = 6;
   localparam int CLA_MAX_WIDTH = 16;

   typedef struct packed {
      logic g;
      logic p;
      logic h;
   } gph_bit_t;

   // Every carry is a flat sum-of-products of g/p/cin; no carry is built from a lower carry.
   function automatic logic [CLA_MAX_WIDTH:0] cla_carries(
      input logic [CLA_MAX_WIDTH-1:0] g,
      input logic [CLA_MAX_WIDTH-1:0] p,
      input logic                     cin
   );
      logic [CLA_MAX_WIDTH:0] c;
      logic                   term;
      c    = '0;
      c[0] = cin;
      for (int i = 0; i < CLA_MAX_WIDTH; i++) begin
         term = cin;
         for (int k = 0; k <= i; k++) term = term & p[k];
         c[i+1] = term;
         for (int j = 0; j <= i; j++) begin
            term = g[j];
            for (int k = j + 1; k <= i; k++) term = term & p[k];
            c[i+1] = c[i+1] | term;
         end
      end
      return c;
   endfunction

endpackage

// File: rtl/cla_sum_pipe_if.sv
// Operand/result handshake bundle for cla_sum_pipe; the design side uses the slave modport.
interface cla_sum_pipe_if
   import cla_pkg::*;
#(
   parameter int WIDTH = CLA_WIDTH_DEF
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] sum;
   logic             cout;
   logic             grp_g;
   logic             grp_p;
   logic             ovf;

   modport master (
      output in_valid, a, b, cin, out_ready,
      input  in_ready, out_valid, sum, cout, grp_g, grp_p, ovf
   );

   modport slave (
      input  in_valid, a, b, cin, out_ready,
      output in_ready, out_valid, sum, cout, grp_g, grp_p, ovf
   );
endinterface

// File: rtl/gph_cell.sv
// One-bit generate/propagate/half-sum cell for the lookahead adder.
module gph_cell
   import cla_pkg::*;
(
   input  logic x,
   input  logic y,
   output logic g,
   output logic p,
   output logic h
);
   gph_bit_t bits;

   always_comb begin
      bits.g = x & y;
      bits.p = x | y;
      bits.h = x ^ y;
   end

   assign g = bits.g;
   assign p = bits.p;
   assign h = bits.h;
endmodule

// File: rtl/cla_sum_pipe.sv
// Two-stage pipelined carry-lookahead sum with valid/ready handshake.
// Optional signed overflow output is built when CLA_SUM_OVF_EN is defined.
module cla_sum_pipe
   import cla_pkg::*;
#(
   parameter int WIDTH = CLA_WIDTH_DEF
)(
   input  logic           clk,
   input  logic           rst,
   cla_sum_pipe_if.slave  bus
);
   logic [WIDTH-1:0] g_cur, p_cur, h_cur;
   logic [WIDTH-1:0] g1_reg, p1_reg, h1_reg;
   logic             cin1_reg;
   logic             v1_reg, v1_next;
   logic             v2_reg, v2_next;
   logic [WIDTH-1:0] sum_reg;
   logic             cout_reg, grp_g_reg, grp_p_reg;
   logic             acc1, adv2, in_ready;
   logic [CLA_MAX_WIDTH:0] c_full, c_nocin;
   logic [WIDTH:0]   c;
   logic             unused_carry;

   generate
      for (genvar gi = 0; gi < WIDTH; gi++) begin : g_cell
         gph_cell u_cell (
            .x (bus.a[gi]),
            .y (bus.b[gi]),
            .g (g_cur[gi]),
            .p (p_cur[gi]),
            .h (h_cur[gi])
         );
      end
   endgenerate

   assign adv2     = v1_reg & (~v2_reg | bus.out_ready);
   assign in_ready = ~v1_reg | adv2;
   assign acc1     = bus.in_valid & in_ready;

   always_comb begin
      v1_next = v1_reg;
      v2_next = v2_reg;
      if (acc1)
         v1_next = 1'b1;
      else if (adv2)
         v1_next = 1'b0;
      if (adv2)
         v2_next = 1'b1;
      else if (bus.out_ready)
         v2_next = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         v1_reg <= 1'b0;
         v2_reg <= 1'b0;
      end else begin
         v1_reg <= v1_next;
         v2_reg <= v2_next;
      end
   end

   always_ff @(posedge clk) begin
      if (acc1) begin
         g1_reg   <= g_cur;
         p1_reg   <= p_cur;
         h1_reg   <= h_cur;
         cin1_reg <= bus.cin;
      end
   end

   assign c_full       = cla_carries(CLA_MAX_WIDTH'(g1_reg), CLA_MAX_WIDTH'(p1_reg), cin1_reg);
   assign c_nocin      = cla_carries(CLA_MAX_WIDTH'(g1_reg), CLA_MAX_WIDTH'(p1_reg), 1'b0);
   assign c            = c_full[WIDTH:0];
   assign unused_carry = ^{c_full, c_nocin};

   // Result registers are cleared so the outputs read zero straight after reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         sum_reg   <= '0;
         cout_reg  <= 1'b0;
         grp_g_reg <= 1'b0;
         grp_p_reg <= 1'b0;
      end else if (adv2) begin
         sum_reg   <= h1_reg ^ c[WIDTH-1:0];
         cout_reg  <= c[WIDTH];
         grp_g_reg <= c_nocin[WIDTH];
         grp_p_reg <= &p1_reg;
      end
   end

`ifdef CLA_SUM_OVF_EN
   logic ovf_reg;

   always_ff @(posedge clk) begin
      if (rst)
         ovf_reg <= 1'b0;
      else if (adv2)
         ovf_reg <= c[WIDTH] ^ c[WIDTH-1];
   end

   assign bus.ovf = ovf_reg;
`else
   assign bus.ovf = 1'b0;
`endif

   assign bus.in_ready  = in_ready;
   assign bus.out_valid = v2_reg;
   assign bus.sum       = sum_reg;
   assign bus.cout      = cout_reg;
   assign bus.grp_g     = grp_g_reg;
   assign bus.grp_p     = grp_p_reg;
endmodule

// File: tb/tb_cla_sum_pipe.sv
// Directed bench for cla_sum_pipe with a result scoreboard; honours CLA_SUM_OVF_EN.
module tb_cla_sum_pipe;
   localparam int W = 6;

   typedef struct packed {
      logic [W-1:0] sum;
      logic         cout;
      logic         grp_g;
      logic         grp_p;
      logic         ovf;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   int   chk_cnt  = 0;
   int   pass_cnt = 0;
   int   cyc      = 0;
   exp_t sb_q[$];
   int   pop_cyc[$];

   cla_sum_pipe_if #(.WIDTH(W)) bus ();

   cla_sum_pipe #(.WIDTH(W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   function automatic exp_t model(input logic [W-1:0] xa, input logic [W-1:0] xb, input logic xc);
      exp_t     m;
      logic [W:0] t, t0;
      t       = {1'b0, xa} + {1'b0, xb} + (W+1)'(xc);
      t0      = {1'b0, xa} + {1'b0, xb};
      m.sum   = t[W-1:0];
      m.cout  = t[W];
      m.grp_g = t0[W];
      m.grp_p = &(xa | xb);
`ifdef CLA_SUM_OVF_EN
      m.ovf   = (xa[W-1] == xb[W-1]) && (t[W-1] != xa[W-1]);
`else
      m.ovf   = 1'b0;
`endif
      return m;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      chk_cnt++;
      assert (obs === exp) pass_cnt++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   // Scoreboard side: a beat transfers at the next rising edge when valid and ready both hold here.
   always @(negedge clk) begin
      exp_t e;
      if (rst === 1'b0 && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
         check("beat_expected", 32'(sb_q.size() > 0), 32'd1);
         if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            pop_cyc.push_back(cyc);
            $display("recv sum=%0d cout=%0b grp_g=%0b grp_p=%0b ovf=%0b", bus.sum, bus.cout,
                     bus.grp_g, bus.grp_p, bus.ovf);
            check("sum",   32'(bus.sum),   32'(e.sum));
            check("cout",  32'(bus.cout),  32'(e.cout));
            check("grp_g", 32'(bus.grp_g), 32'(e.grp_g));
            check("grp_p", 32'(bus.grp_p), 32'(e.grp_p));
            check("ovf",   32'(bus.ovf),   32'(e.ovf));
         end
      end
   end

   task automatic send(input logic [W-1:0] xa, input logic [W-1:0] xb, input logic xc);
      int n    = 0;
      bit done = 1'b0;
      bus.in_valid = 1'b1;
      bus.a        = xa;
      bus.b        = xb;
      bus.cin      = xc;
      while (!done && n < 40) begin
         @(negedge clk);
         if (bus.in_ready === 1'b1) begin
            sb_q.push_back(model(xa, xb, xc));
            $display("send a=%0d b=%0d cin=%0b", xa, xb, xc);
            done = 1'b1;
         end
         @(posedge clk);
         #1;
         n++;
      end
      bus.in_valid = 1'b0;
      if (!done) check("send_accept", 32'd0, 32'd1);
   endtask

   task automatic drain();
      int n = 0;
      while (sb_q.size() != 0 && n < 50) begin
         @(posedge clk);
         n++;
      end
      #1;
      check("drain", 32'(sb_q.size()), 32'd0);
   endtask

   initial begin
      int   start;
      exp_t e1;

      // Reset held with a beat offered
      rst           = 1'b1;
      bus.in_valid  = 1'b1;
      bus.a         = '0;
      bus.b         = '0;
      bus.cin       = 1'b0;
      bus.out_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst          = 1'b0;
      bus.in_valid = 1'b0;
      @(negedge clk);
      check("rst_out_valid", 32'(bus.out_valid), 32'd0);
      check("rst_sum",       32'(bus.sum),       32'd0);
      check("rst_cout",      32'(bus.cout),      32'd0);
      check("rst_grp_g",     32'(bus.grp_g),     32'd0);
      check("rst_grp_p",     32'(bus.grp_p),     32'd0);
      check("rst_ovf",       32'(bus.ovf),       32'd0);
      check("rst_in_ready",  32'(bus.in_ready),  32'd1);
      @(posedge clk);
      #1;

      // Full carry chain, with two-clock latency
      bus.out_ready = 1'b1;
      send(6'd63, 6'd1, 1'b0);
      @(negedge clk);
      check("lat_not_yet", 32'(bus.out_valid), 32'd0);
      @(negedge clk);
      check("lat_valid", 32'(bus.out_valid), 32'd1);
      drain();

      // Pure propagate chain driven by cin
      send(6'd21, 6'd42, 1'b1);
      drain();

      // Back-to-back random beats
      start = pop_cyc.size();
      for (int i = 0; i < 8; i++)
         send(6'($urandom_range(0, 63)), 6'($urandom_range(0, 63)), 1'($urandom_range(0, 1)));
      drain();
      check("burst_count", 32'(pop_cyc.size() - start), 32'd8);
      if (pop_cyc.size() - start == 8)
         check("burst_span", 32'(pop_cyc[start+7] - pop_cyc[start]), 32'd7);

      // Consumer stall with three beats offered
      bus.out_ready = 1'b0;
      start = pop_cyc.size();
      e1 = model(6'd10, 6'd20, 1'b0);
      send(6'd10, 6'd20, 1'b0);
      send(6'd33, 6'd44, 1'b1);
      fork
         send(6'd55, 6'd7, 1'b0);
         begin
            repeat (2) begin
               @(negedge clk);
               check("stall_in_ready",  32'(bus.in_ready),  32'd0);
               check("stall_out_valid", 32'(bus.out_valid), 32'd1);
               check("stall_sum",       32'(bus.sum),       32'(e1.sum));
            end
            @(posedge clk);
            #1;
            bus.out_ready = 1'b1;
         end
      join
      drain();
      check("stall_delivered", 32'(pop_cyc.size() - start), 32'd3);

      // Signed overflow cases
      send(6'd31, 6'd1, 1'b0);
      send(6'd32, 6'd32, 1'b0);
      drain();

      // Reset in the middle of a stall
      bus.out_ready = 1'b0;
      send(6'd5, 6'd6, 1'b0);
      send(6'd7, 6'd8, 1'b1);
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("midrst_out_valid", 32'(bus.out_valid), 32'd0);
      check("midrst_sum",       32'(bus.sum),       32'd0);
      sb_q.delete();
      @(posedge clk);
      #1;
      rst           = 1'b0;
      bus.out_ready = 1'b1;
      @(negedge clk);
      check("post_rst_in_ready", 32'(bus.in_ready), 32'd1);
      @(posedge clk);
      #1;
      send(6'd17, 6'd9, 1'b1);
      drain();

      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end
endmodule
